// File: rtl/mux_8bit_reg.sv
// mux_8bit_reg: registered 2:1 word multiplexer with a valid strobe,
// last-select tracking and a saturating select-toggle counter.
//
// Optional feature macro: MUX_8BIT_REG_PARITY_EN
//   Defined   -> adds registered output y_parity (XOR-reduction of the
//                selected word), reset to 0, held while idle.
//   Undefined -> y_parity port and logic are absent.
//
// Parameters:
//   WIDTH      data width of a, b and y (>= 1)
//   CNT_WIDTH  width of the toggle counter (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   a, b        operand words (sel=0 -> a, sel=1 -> b)
//   sel         select bit
//   in_valid    qualifies a/b/sel this cycle
//   y           registered mux result
//   y_valid     high one cycle after an accepted sample
//   y_parity    (optional) registered parity of the selected word
//   sel_q       select of the last accepted sample
//   toggle_cnt  saturating count of accepted select changes
module mux_8bit_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sel,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
`ifdef MUX_8BIT_REG_PARITY_EN
    output logic                 y_parity,
`endif
    output logic                 sel_q,
    output logic [CNT_WIDTH-1:0] toggle_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     mux_word_c;
    logic [WIDTH-1:0]     y_q,          y_d;
    logic                 y_valid_q,    y_valid_d;
    logic                 sel_d;
    logic [CNT_WIDTH-1:0] toggle_cnt_q, toggle_cnt_d;
`ifdef MUX_8BIT_REG_PARITY_EN
    logic                 y_parity_q,   y_parity_d;
`endif

    // Selected word; only consumed when a sample is accepted.
    assign mux_word_c = sel ? b : a;

    // Next-state: hold everything except y_valid, which is a one-cycle strobe.
    always_comb begin
        y_d          = y_q;
        y_valid_d    = 1'b0;
        sel_d        = sel_q;
        toggle_cnt_d = toggle_cnt_q;
`ifdef MUX_8BIT_REG_PARITY_EN
        y_parity_d   = y_parity_q;
`endif
        if (in_valid) begin
            y_d       = mux_word_c;
            y_valid_d = 1'b1;
            sel_d     = sel;
`ifdef MUX_8BIT_REG_PARITY_EN
            y_parity_d = ^mux_word_c;
`endif
            // Counter saturates at all-ones instead of wrapping.
            if ((sel != sel_q) && (toggle_cnt_q != CNT_MAX)) begin
                toggle_cnt_d = toggle_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers; synchronous reset overrides any sample this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q          <= '0;
            y_valid_q    <= 1'b0;
            sel_q        <= 1'b0;
            toggle_cnt_q <= '0;
`ifdef MUX_8BIT_REG_PARITY_EN
            y_parity_q   <= 1'b0;
`endif
        end else begin
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
            sel_q        <= sel_d;
            toggle_cnt_q <= toggle_cnt_d;
`ifdef MUX_8BIT_REG_PARITY_EN
            y_parity_q   <= y_parity_d;
`endif
        end
    end

    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign toggle_cnt = toggle_cnt_q;
`ifdef MUX_8BIT_REG_PARITY_EN
    assign y_parity   = y_parity_q;
`endif

endmodule

// File: tb/tb_mux_8bit_reg.sv
// Randomised bench for mux_8bit_reg against a behavioural model.
module tb_mux_8bit_reg;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned CNT_SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic          sel;
    logic          in_valid;
    logic [W-1:0]  y;
    logic          y_valid;
    logic          sel_q;
    logic [CW-1:0] toggle_cnt;
`ifdef MUX_8BIT_REG_PARITY_EN
    logic          y_parity;
`endif

    int n_tests;
    int n_fail;

    // Behavioural model state
    int m_y, m_valid, m_sel, m_cnt, m_par;

    mux_8bit_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .y         (y),
        .y_valid   (y_valid),
`ifdef MUX_8BIT_REG_PARITY_EN
        .y_parity  (y_parity),
`endif
        .sel_q     (sel_q),
        .toggle_cnt(toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input int r, input int va, input int vb, input int s, input int v);
        if (r == 0) begin
            m_y = 0; m_valid = 0; m_sel = 0; m_cnt = 0; m_par = 0;
        end else if (v != 0) begin
            m_y     = (s != 0) ? vb : va;
            m_valid = 1;
            if (s != m_sel) m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
            m_sel   = s;
            m_par   = $countones(m_y) % 2;
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic check_all();
        check("y", 32'(y), 32'(m_y));
        check("y_valid", 32'(y_valid), 32'(m_valid));
        check("sel_q", 32'(sel_q), 32'(m_sel));
        check("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
`ifdef MUX_8BIT_REG_PARITY_EN
        check("y_parity", 32'(y_parity), 32'(m_par));
`endif
    endtask

    // One clock: drive on falling edge, sample #1 after the rising edge.
    task automatic step(input int r, input int va, input int vb, input int s, input int v);
        @(negedge clk);
        rst_n    = (r != 0);
        a        = W'(va);
        b        = W'(vb);
        sel      = (s != 0);
        in_valid = (v != 0);
        @(posedge clk);
        model_update(r, va, vb, s, v);
        #1;
        check_all();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_y = 0; m_valid = 0; m_sel = 0; m_cnt = 0; m_par = 0;
        rst_n = 1'b0; a = '0; b = '0; sel = 1'b0; in_valid = 1'b0;

        // Reset
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_cnt", 32'(toggle_cnt), 32'd0);

        // Directed sequence
        step(1, 216, 20, 1, 1);
        check("first_y", 32'(y), 32'd20);
        check("first_cnt", 32'(toggle_cnt), 32'd1);
        step(1, 63, 202, 0, 1);
        step(1, 231, 185, 1, 1);
        step(1, 229, 84, 0, 1);
        check("b2b_y", 32'(y), 32'd229);
        check("b2b_cnt", 32'(toggle_cnt), 32'd4);
        for (int i = 0; i < 3; i++) step(1, i * 17, i * 31, i % 2, 0);
        check("idle_y", 32'(y), 32'd229);
        check("idle_valid", 32'(y_valid), 32'd0);

        // Saturation
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), (i % 2 == 0) ? 1 : 0, 1);
        check("sat_cnt", 32'(toggle_cnt), 32'(CNT_SAT));
        step(1, 1, 2, 0, 1);
        check("sat_hold", 32'(toggle_cnt), 32'(CNT_SAT));

        // Reset concurrent with a valid sample
        step(0, 255, 0, 0, 1);
        check("rst_mid_y", 32'(y), 32'd0);
        check("rst_mid_valid", 32'(y_valid), 32'd0);

`ifdef MUX_8BIT_REG_PARITY_EN
        step(1, 0, 7, 1, 1);
        check("par_odd", 32'(y_parity), 32'd1);
        step(1, 3, 0, 0, 1);
        check("par_even", 32'(y_parity), 32'd0);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 49) == 0) ? 0 : 1,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7) ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_8bit_reg.md
Name: mux_8bit_reg

Overview:
Registered 2:1 multiplexer for data words, 8 bits wide by default. It selects between operand words a and b with a single select bit and presents the result one clock later with a valid strobe. It also tracks the last accepted select and counts select toggles for debug. It sits in the datapath wherever an operand source is chosen ahead of a pipelined consumer.

Parameters:
WIDTH, 8, data width of a, b and y (minimum 1)
CNT_WIDTH, 8, width of the select-toggle counter (minimum 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
a  input  WIDTH  operand passed when sel=0
b  input  WIDTH  operand passed when sel=1
sel  input  1  select: 0 -> a, 1 -> b
in_valid  input  1  qualifies a/b/sel this cycle
y  output  WIDTH  registered mux result
y_valid  output  1  high one cycle after an accepted sample
sel_q  output  1  select of the last accepted sample
toggle_cnt  output  CNT_WIDTH  number of accepted samples whose sel differed from the previous accepted sel; saturating

Behaviour:
- Reset: rst_n low at a rising clk edge sets y=0, y_valid=0, sel_q=0, toggle_cnt=0.
  - Reset takes priority over every other input.
  - Reset mid-stream discards any sample presented in that same cycle.
- Accept: a sample is accepted on a rising edge where rst_n=1 and in_valid=1.
  - y <= (sel ? b : a), computed on the full WIDTH.
  - Bits are passed unmodified; no arithmetic.
  - y_valid <= 1 and sel_q <= sel.
- Idle: rising edge with rst_n=1 and in_valid=0.
  - y holds its previous value.
  - sel_q holds.
  - y_valid <= 0.
- Latency: exactly 1 cycle from accepted sample to y/y_valid.
  - Back-to-back samples with in_valid held high produce a new result every cycle.
- No backpressure: the consumer must take y while y_valid=1.
- Toggle counter: on accept, if sel != sel_q then toggle_cnt <= toggle_cnt+1.
  - The counter saturates at all-ones and never wraps.
  - The first accepted sample after reset compares against the reset value sel_q=0.
- X handling: sel is treated as a strict 0/1 value. A sel of X/Z is not supported; the bench must drive known values.
- No combinational path from inputs to outputs.

Optional Feature:
MUX_8BIT_REG_PARITY_EN
- Defined:
  - Adds output y_parity (1 bit), registered alongside y, equal to the XOR-reduction of the selected word.
  - y_parity resets to 0 and holds when idle, exactly like y.
- Undefined:
  - The y_parity port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then a=216, b=20, sel=1, in_valid=1 -> next cycle y=20, y_valid=1, sel_q=1, toggle_cnt=1.
- a=63, b=202, sel=0 accepted -> y=63, sel_q=0, toggle_cnt=2.
  - Then a=231, b=185, sel=1 -> y=185, toggle_cnt=3.
  - Then a=229, b=84, sel=0 -> y=229, toggle_cnt=4.
- in_valid=0 for 3 cycles after y=229 -> y stays 229, y_valid=0, toggle_cnt unchanged.
- 300 accepted samples alternating sel starting at 1 -> toggle_cnt saturates at 255 and stays 255.
- rst_n=0 in the same cycle as in_valid=1 with a=8'hFF, sel=0 -> next cycle y=0, y_valid=0, toggle_cnt=0.
- With MUX_8BIT_REG_PARITY_EN defined: sel=1, b=8'b0000_0111 -> y_parity=1; then sel=0, a=8'b0000_0011 -> y_parity=0.
